// File: rtl/hex_display_scanner.sv
// Hex display scanner: multiplexes a latched value onto a common-anode 7-segment display.
// Latency: outputs are registered and reflect the current slot/digit/shadow in the same cycle.
// Backpressure: none; the display is free-running, and freeze holds the latched value at frame end.
//
// Ports:
//   clock        - single clock, all logic on posedge
//   isReset      - synchronous active-high reset
//   value        - value to display, latched into shadow once per frame
//   freeze       - 1: keep the current shadow at frame end
//   segments     - {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   digitEnable  - bit i drives digit i (0 = least-significant nibble), polarity set by DIGIT_ACTIVE_LOW
//   frameDone    - single-cycle pulse in the first cycle of each new frame
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading-zero digits (digit 0 is always shown).

module hex_display_scanner #(
  parameter int VALUE_WIDTH      = 8,
  parameter int NUM_DIGITS       = 2,
  parameter int REFRESH_DIV      = 50000,
  parameter int BLANK_CYCLES     = 500,
  parameter int SEG_ACTIVE_LOW   = 1,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic                   clock,
  input  logic                   isReset,
  input  logic [VALUE_WIDTH-1:0] value,
  input  logic                   freeze,
  output logic [6:0]             segments,
  output logic [NUM_DIGITS-1:0]  digitEnable,
  output logic                   frameDone
);

  localparam int SW     = NUM_DIGITS * 4;
  localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0]     BLANK_END = SLOT_W'(BLANK_CYCLES);
  localparam logic [DIG_W-1:0]      DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF   = (DIGIT_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t                  state_q, state_nx;
  logic [SLOT_W-1:0]       slot_q, slot_nx;
  logic [DIG_W-1:0]        digit_q, digit_nx;
  logic [SW-1:0]           shadow_q, shadow_nx;
  logic [SW-1:0]           value_fit;
  logic                    frame_end;
  logic [3:0]              nibble;
  logic                    lz_blank;
  logic [6:0]              seg_lit;
  logic [6:0]              seg_nx;
  logic [NUM_DIGITS-1:0]   en_nx;

  // Zero-extend or truncate the input to exactly the displayable width.
  generate
    if (VALUE_WIDTH >= SW) begin : g_trunc
      assign value_fit = value[SW-1:0];
    end else begin : g_ext
      assign value_fit = {{(SW - VALUE_WIDTH){1'b0}}, value};
    end
  endgenerate

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h3F;
      4'h1: font = 7'h06;
      4'h2: font = 7'h5B;
      4'h3: font = 7'h4F;
      4'h4: font = 7'h66;
      4'h5: font = 7'h6D;
      4'h6: font = 7'h7D;
      4'h7: font = 7'h07;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h6F;
      4'hA: font = 7'h77;
      4'hB: font = 7'h7C;
      4'hC: font = 7'h39;
      4'hD: font = 7'h5E;
      4'hE: font = 7'h79;
      default: font = 7'h71;
    endcase
  endfunction

  // Everything is computed from next-cycle counters so the registered outputs
  // line up with the counters they describe, with no visible pipeline delay.
  always_comb begin
    frame_end = 1'b0;
    slot_nx   = slot_q;
    digit_nx  = digit_q;
    shadow_nx = shadow_q;
    state_nx  = state_q;
    nibble    = 4'h0;
    lz_blank  = 1'b0;
    seg_lit   = 7'h00;
    seg_nx    = SEG_OFF;
    en_nx     = DIG_OFF;

    frame_end = (slot_q == SLOT_LAST) && (digit_q == DIG_LAST);

    if (slot_q == SLOT_LAST) begin
      slot_nx  = '0;
      digit_nx = (digit_q == DIG_LAST) ? '0 : digit_q + DIG_W'(1);
    end else begin
      slot_nx  = slot_q + SLOT_W'(1);
    end

    if (frame_end && !freeze) begin
      shadow_nx = value_fit;
    end

    // Slot FSM: each slot opens blanked and turns on once the blank window ends.
    case (state_q)
      ST_BLANK: if (slot_nx == BLANK_END) state_nx = ST_ON;
      ST_ON:    if (slot_nx == '0)        state_nx = ST_BLANK;
      default:                            state_nx = ST_BLANK;
    endcase

    nibble = shadow_nx[{digit_nx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    // Digit i>0 is dark when it and every more-significant nibble are zero.
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if ((digit_nx == DIG_W'(i)) && ((shadow_nx >> (4 * i)) == '0)) begin
        lz_blank = 1'b1;
      end
    end
`endif

    seg_lit = lz_blank ? 7'h00 : font(nibble);

    if (state_nx == ST_ON) begin
      en_nx  = DIG_OFF ^ (NUM_DIGITS'(1) << digit_nx);
      seg_nx = SEG_OFF ^ seg_lit;
    end
  end

  always_ff @(posedge clock) begin
    if (isReset) begin
      state_q     <= ST_BLANK;
      slot_q      <= '0;
      digit_q     <= '0;
      shadow_q    <= '0;
      segments    <= SEG_OFF;
      digitEnable <= DIG_OFF;
      frameDone   <= 1'b0;
    end else begin
      state_q     <= state_nx;
      slot_q      <= slot_nx;
      digit_q     <= digit_nx;
      shadow_q    <= shadow_nx;
      segments    <= seg_nx;
      digitEnable <= en_nx;
      frameDone   <= frame_end;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
module tb_hex_display_scanner;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int ND    = 2;
  localparam int FRAME = DIV * ND;

  logic       clock = 1'b0;
  logic       isReset = 1'b1;
  logic [7:0] value = 8'h00;
  logic       freeze = 1'b0;
  logic [6:0] segments;
  logic [1:0] digitEnable;
  logic       frameDone;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycles since reset release and the displayed value.
  int         cyc = 0;
  logic [7:0] shadow = 8'h00;

  logic [6:0] font_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  hex_display_scanner #(
    .VALUE_WIDTH(8), .NUM_DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK),
    .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(1)
  ) dut (
    .clock(clock), .isReset(isReset), .value(value), .freeze(freeze),
    .segments(segments), .digitEnable(digitEnable), .frameDone(frameDone)
  );

  always #5 clock = ~clock;

  // Expected {digitEnable, segments, frameDone} for the model's current cycle.
  function automatic logic [9:0] expect_out(input int c, input logic [7:0] sh);
    int         slot, dig;
    logic [3:0] nib;
    logic [1:0] en;
    logic [6:0] seg;
    logic       lz;
    slot = c % DIV;
    dig  = (c / DIV) % ND;
    nib  = 4'((sh >> (4 * dig)) & 8'h0F);
    lz   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    lz   = (dig > 0) && ((sh >> (4 * dig)) == 8'h00);
`endif
    if (slot < BLANK) begin
      en  = 2'b11;
      seg = 7'h7F;
    end else begin
      en  = ~(2'b01 << dig);
      seg = lz ? 7'h7F : ~font_tab[nib];
    end
    return {en, seg, (c > 0) && (c % FRAME == 0)};
  endfunction

  // Advance one clock: update the model with the inputs the DUT sampled, then
  // land on the falling edge where outputs are compared and inputs changed.
  task automatic tick();
    @(posedge clock);
    if (isReset) begin
      cyc    = 0;
      shadow = 8'h00;
    end else begin
      if ((cyc % FRAME == FRAME - 1) && !freeze) shadow = value;
      cyc++;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    isReset = 1'b1;
    value   = 8'h3A;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({digitEnable, segments, frameDone} !== {2'b11, 7'h7F, 1'b0}) begin
        errors++;
        $display("FAIL reset: got en=%b seg=%h fd=%b, want en=11 seg=7f fd=0",
                 digitEnable, segments, frameDone);
      end
    end
    isReset = 1'b0;
  endtask

  task automatic test_scan();
    logic [9:0] exp;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (i > 0) tick();
      exp = expect_out(cyc, shadow);
      checks++;
      if ({digitEnable, segments, frameDone} !== exp) begin
        errors++;
        $display("FAIL scan cyc=%0d: got %b_%h_%b, want %b_%h_%b", cyc,
                 digitEnable, segments, frameDone, exp[9:8], exp[7:1], exp[0]);
      end
      if (cyc == 9 || cyc == 13 || cyc == 2) begin
        checks++;
        if ({digitEnable, segments} !== ((cyc == 9) ? {2'b10, 7'h08} :
                                         (cyc == 13) ? {2'b01, 7'h30} : {2'b10, 7'h40})) begin
          errors++;
          $display("FAIL scan_digit cyc=%0d: got en=%b seg=%h", cyc, digitEnable, segments);
        end
      end
      if (cyc == 8) begin
        checks++;
        if (frameDone !== 1'b1) begin
          errors++;
          $display("FAIL frame_pulse cyc=8: got %b want 1", frameDone);
        end
      end
    end
  endtask

  task automatic test_freeze();
    logic [9:0] exp;
    freeze = 1'b1;
    value  = 8'hFF;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      exp = expect_out(cyc, shadow);
      checks++;
      if ({digitEnable, segments, frameDone} !== exp || shadow !== 8'h3A) begin
        errors++;
        $display("FAIL freeze cyc=%0d: got %b_%h_%b, want %b_%h_%b shadow %h", cyc,
                 digitEnable, segments, frameDone, exp[9:8], exp[7:1], exp[0], shadow);
      end
    end
    freeze = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      exp = expect_out(cyc, shadow);
      checks++;
      if ({digitEnable, segments, frameDone} !== exp) begin
        errors++;
        $display("FAIL unfreeze cyc=%0d: got %b_%h_%b, want %b_%h_%b", cyc,
                 digitEnable, segments, frameDone, exp[9:8], exp[7:1], exp[0]);
      end
      if (cyc % FRAME == 1 && shadow == 8'hFF) begin
        checks++;
        if (segments !== 7'h0E) begin
          errors++;
          $display("FAIL show_ff cyc=%0d: got seg=%h want 0e", cyc, segments);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] exp;
    for (int i = 0; i < 400; i++) begin
      value  = 8'($urandom);
      freeze = ($urandom_range(0, 3) == 0);
      tick();
      exp = expect_out(cyc, shadow);
      checks++;
      if ({digitEnable, segments, frameDone} !== exp) begin
        errors++;
        $display("FAIL random cyc=%0d: got %b_%h_%b, want %b_%h_%b", cyc,
                 digitEnable, segments, frameDone, exp[9:8], exp[7:1], exp[0]);
      end
    end
    freeze = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [9:0] exp;
    value = 8'h77;
    for (int i = 0; i < 2 * FRAME && (cyc % FRAME) != 6; i++) tick();
    isReset = 1'b1;
    tick();
    checks++;
    if ({digitEnable, segments, frameDone} !== {2'b11, 7'h7F, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got en=%b seg=%h fd=%b", digitEnable, segments, frameDone);
    end
    isReset = 1'b0;
    // Restarted scan shows shadow=0 for the whole first frame.
    for (int i = 0; i < FRAME; i++) begin
      tick();
      exp = expect_out(cyc, shadow);
      checks++;
      if ({digitEnable, segments, frameDone} !== exp) begin
        errors++;
        $display("FAIL restart cyc=%0d: got %b_%h_%b, want %b_%h_%b", cyc,
                 digitEnable, segments, frameDone, exp[9:8], exp[7:1], exp[0]);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [9:0] exp;
    value = 8'h05;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      exp = expect_out(cyc, shadow);
      checks++;
      if ({digitEnable, segments, frameDone} !== exp) begin
        errors++;
        $display("FAIL leading cyc=%0d: got %b_%h_%b, want %b_%h_%b", cyc,
                 digitEnable, segments, frameDone, exp[9:8], exp[7:1], exp[0]);
      end
      if (shadow == 8'h05 && (cyc % FRAME) == 2) begin
        checks++;
        if ({digitEnable, segments} !== {2'b10, 7'h12}) begin
          errors++;
          $display("FAIL digit0_5: got en=%b seg=%h want 10/12", digitEnable, segments);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_freeze();
    test_random();
    test_reset_mid();
    test_leading_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
